regfile_operand_stage: RTL and testbench
========================================

REGFILE_OPERAND_STAGE -- requirements
Module: regfile_operand_stage

Interface
REQ-001 Parameter: DW, 16, datapath word width in bits.
REQ-002 Parameter: NREG, 8, number of registers, addressed by 3 bits.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous active-low reset.
REQ-005 Port: write  input  1  register-file write enable.
REQ-006 Port: writenum  input  3  write address.
REQ-007 Port: data_in  input  DW  write data.
REQ-008 Port: req_valid  input  1  operand-fetch request present.
REQ-009 Port: req_ready  output  1  stage can accept a request.
REQ-010 Port: readnum_a  input  3  A-operand register address.
REQ-011 Port: readnum_b  input  3  B-operand register address.
REQ-012 Port: shift_in  input  2  shift code carried with request: 00 pass, 01 left by 1, 10 logical right by 1, 11 arithmetic right by 1.
REQ-013 Port: out_valid  output  1  head entry valid toward downstream shifter/ALU.
REQ-014 Port: out_ready  input  1  downstream accepts head entry.
REQ-015 Port: a_out  output  DW  head entry A operand.
REQ-016 Port: b_out  output  DW  head entry B operand, drives shifter input.
REQ-017 Port: shift_out  output  2  head entry shift code, drives shifter control.

Function
REQ-018 Register file SHALL write data_in to register writenum on a rising edge with write=1; contents otherwise hold.
REQ-019 Request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; else ignored.
REQ-020 Accepted entry SHALL be snapshot {R[readnum_a], R[readnum_b], shift_in} taken at acceptance edge.
REQ-021 Write-first bypass: if write=1 and writenum equals readnum_a or readnum_b in the accepting cycle, that operand SHALL be data_in.
REQ-022 Buffered entries SHALL NOT change on later writes to the register file.
REQ-023 Output buffer SHALL be a 2-entry in-order FIFO; state EMPTY (0), ONE (1), FULL (2).
REQ-024 Transitions: push only -> count+1; pop only (out_valid and out_ready) -> count-1; push and pop same edge -> count unchanged; neither -> hold.
REQ-025 req_ready SHALL be 1 when count<2, registered/derived from state only, no combinational path from out_ready.
REQ-026 out_valid SHALL be 1 when count>0; latency request-accept edge to out_valid high = same edge (visible next cycle).
REQ-027 a_out, b_out, shift_out SHALL present head entry while out_valid=1 and all zero while out_valid=0.
REQ-028 Head entry SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 Push into EMPTY while popping is impossible (no valid head); push into ONE with pop SHALL make new entry head next cycle.
REQ-030 Pop with out_ready=1 while EMPTY SHALL have no effect.

Reset
REQ-031 reset_n=0 SHALL immediately, independent of clk, clear all registers to 0, count to EMPTY, out_valid to 0, req_ready to 1, and a_out/b_out/shift_out to 0.
REQ-032 Reset asserted mid-operation SHALL discard buffered entries and block writes; first edge after deassertion SHALL behave as from EMPTY.

Verification
REQ-033 Reset, then write R3=16'hF0CF; request a=3, b=3, shift=11 -> out_valid next cycle, a_out=b_out=16'hF0CF, shift_out=11.
REQ-034 Same-cycle write R5=16'h1234 and request b=5 -> b_out=16'h1234 (bypass); later write R5=16'h0000 leaves buffered b_out=16'h1234.
REQ-035 out_ready=0, issue 3 requests (shift 00,01,10) -> req_ready=0 after second accept, third held; release out_ready -> entries pop in order 00,01,10.
REQ-036 count=ONE, simultaneous push and pop -> count stays ONE, new entry on outputs next cycle, req_ready stays 1.
REQ-037 FULL state, assert reset_n=0 between edges -> out_valid=0, req_ready=1, outputs zero immediately; read of prior-written R3 returns 16'h0000.

Source files
------------

// File: rtl/regfile_operand_stage.sv
// Register file with write-first operand fetch feeding a 2-entry in-order
// output buffer toward the downstream shifter/ALU.
module regfile_operand_stage #(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          write,
    input  logic [2:0]    writenum,
    input  logic [DW-1:0] data_in,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    readnum_a,
    input  logic [2:0]    readnum_b,
    input  logic [1:0]    shift_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic [1:0]    shift_out
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_rf [NREG];

    // Slot 0 is always the head; slot 1 only holds data in FULL.
    logic [DW-1:0] r_a0, r_a1;
    logic [DW-1:0] r_b0, r_b1;
    logic [1:0]    r_s0, r_s1;

    logic          w_push;
    logic          w_pop;
    logic [DW-1:0] w_op_a;
    logic [DW-1:0] w_op_b;

    assign req_ready = (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign w_push    = req_valid & req_ready;
    assign w_pop     = out_valid & out_ready;

    // A write landing in the accepting cycle must be seen by the snapshot.
    assign w_op_a = (write && (writenum == readnum_a)) ? data_in : r_rf[readnum_a];
    assign w_op_b = (write && (writenum == readnum_b)) ? data_in : r_rf[readnum_b];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (write) begin
            r_rf[writenum] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= EMPTY;
            r_a0    <= '0;
            r_a1    <= '0;
            r_b0    <= '0;
            r_b1    <= '0;
            r_s0    <= '0;
            r_s1    <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_a0    <= w_op_a;
                        r_b0    <= w_op_b;
                        r_s0    <= shift_in;
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        r_a0 <= w_op_a;
                        r_b0 <= w_op_b;
                        r_s0 <= shift_in;
                    end else if (w_push) begin
                        r_a1    <= w_op_a;
                        r_b1    <= w_op_b;
                        r_s1    <= shift_in;
                        r_state <= FULL;
                    end else if (w_pop) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_a0    <= r_a1;
                        r_b0    <= r_b1;
                        r_s0    <= r_s1;
                        r_state <= ONE;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign a_out     = out_valid ? r_a0 : '0;
    assign b_out     = out_valid ? r_b0 : '0;
    assign shift_out = out_valid ? r_s0 : 2'b00;

endmodule

// File: tb/tb_regfile_operand_stage.sv
// Bench for regfile_operand_stage: directed scenarios plus randomized traffic
// checked every cycle against a queue/array model of the stage.
module tb_regfile_operand_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  readnum_a;
    logic [2:0]  readnum_b;
    logic [1:0]  shift_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic [1:0]  shift_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  s;
    } ent_t;

    logic [15:0] m_rf [8];
    ent_t        m_q [$];

    regfile_operand_stage #(.DW(16), .NREG(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .write     (write),
        .writenum  (writenum),
        .data_in   (data_in),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .readnum_a (readnum_a),
        .readnum_b (readnum_b),
        .shift_in  (shift_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .shift_out (shift_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
        m_q.delete();
    endtask

    // One rising edge; the model advances using the inputs held across it.
    task automatic step();
        int   n;
        bit   push, pop;
        ent_t e;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            model_clear();
        end else begin
            n    = m_q.size();
            push = req_valid && (n < 2);
            pop  = out_ready && (n > 0);
            e.a  = (write && writenum == readnum_a) ? data_in : m_rf[readnum_a];
            e.b  = (write && writenum == readnum_b) ? data_in : m_rf[readnum_b];
            e.s  = shift_in;
            if (pop)   void'(m_q.pop_front());
            if (push)  m_q.push_back(e);
            if (write) m_rf[writenum] = data_in;
        end
    endtask

    // Compare process: outputs against the model on every falling edge.
    always @(negedge clk) begin
        logic [15:0] ea, eb;
        logic [1:0]  es;
        ea = 16'h0; eb = 16'h0; es = 2'b00;
        if (m_q.size() > 0) begin
            ea = m_q[0].a; eb = m_q[0].b; es = m_q[0].s;
        end
        chk("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_q.size() > 0});
        chk("cyc_req_ready", {31'b0, req_ready}, {31'b0, m_q.size() < 2});
        chk("cyc_a_out", {16'b0, a_out}, {16'b0, ea});
        chk("cyc_b_out", {16'b0, b_out}, {16'b0, eb});
        chk("cyc_shift_out", {30'b0, shift_out}, {30'b0, es});
    end

    task automatic idle_inputs();
        write = 0; writenum = 0; data_in = 0;
        req_valid = 0; readnum_a = 0; readnum_b = 0; shift_in = 0;
        out_ready = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        model_clear();
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_a_out", {16'b0, a_out}, 32'd0);
        step();
        step();
        reset_n = 1'b1;

        // Plain fetch of a freshly written register, both operands.
        write = 1; writenum = 3; data_in = 16'hF0CF;
        step();
        write = 0;
        req_valid = 1; readnum_a = 3; readnum_b = 3; shift_in = 2'b11;
        step();
        req_valid = 0;
        chk("r33_out_valid", {31'b0, out_valid}, 32'd1);
        chk("r33_a_out", {16'b0, a_out}, 32'hF0CF);
        chk("r33_b_out", {16'b0, b_out}, 32'hF0CF);
        chk("r33_shift_out", {30'b0, shift_out}, 32'd3);
        out_ready = 1;
        step();
        out_ready = 0;

        // Same-cycle write is bypassed; later overwrite does not disturb the entry.
        write = 1; writenum = 5; data_in = 16'h1234;
        req_valid = 1; readnum_a = 0; readnum_b = 5; shift_in = 2'b00;
        step();
        req_valid = 0; data_in = 16'h0000;
        step();
        write = 0;
        chk("r34_b_bypass", {16'b0, b_out}, 32'h1234);
        chk("r34_a_r0", {16'b0, a_out}, 32'h0000);
        out_ready = 1;
        step();
        out_ready = 0;
        chk("r34_drained", {31'b0, out_valid}, 32'd0);

        // Back-pressure: two entries fill the buffer, the third is held off.
        req_valid = 1; readnum_a = 1; readnum_b = 2; shift_in = 2'b00;
        step();
        shift_in = 2'b01;
        step();
        chk("r35_ready_full", {31'b0, req_ready}, 32'd0);
        shift_in = 2'b10;
        step();
        chk("r35_head_held", {30'b0, shift_out}, 32'd0);
        chk("r35_still_full", {31'b0, req_ready}, 32'd0);
        out_ready = 1;
        step();
        chk("r35_pop1", {30'b0, shift_out}, 32'd1);
        chk("r35_ready_one", {31'b0, req_ready}, 32'd1);
        step();
        chk("r36_new_head", {30'b0, shift_out}, 32'd2);
        chk("r36_valid", {31'b0, out_valid}, 32'd1);
        chk("r36_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 0;
        step();
        chk("r35_empty", {31'b0, out_valid}, 32'd0);
        chk("r35_zero_shift", {30'b0, shift_out}, 32'd0);
        out_ready = 0;

        // Asynchronous reset while FULL clears everything, including the file.
        req_valid = 1; readnum_a = 3; readnum_b = 3; shift_in = 2'b01;
        step();
        step();
        req_valid = 0;
        chk("r37_full", {31'b0, req_ready}, 32'd0);
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        chk("r37_valid_now", {31'b0, out_valid}, 32'd0);
        chk("r37_ready_now", {31'b0, req_ready}, 32'd1);
        chk("r37_a_now", {16'b0, a_out}, 32'd0);
        chk("r37_shift_now", {30'b0, shift_out}, 32'd0);
        write = 1; writenum = 3; data_in = 16'hBEEF;
        step();
        reset_n = 1'b1;
        write = 0;
        req_valid = 1; readnum_a = 3; readnum_b = 3; shift_in = 2'b10;
        step();
        req_valid = 0;
        chk("r37_r3_cleared", {16'b0, a_out}, 32'd0);
        chk("r37_from_empty", {31'b0, out_valid}, 32'd1);
        out_ready = 1;
        step();

        // Randomized traffic with occasional mid-cycle resets.
        for (int i = 0; i < 600; i++) begin
            write     = ($urandom_range(0, 2) == 0);
            writenum  = 3'($urandom_range(0, 7));
            data_in   = 16'($urandom);
            req_valid = ($urandom_range(0, 1) == 1);
            readnum_a = 3'($urandom_range(0, 7));
            readnum_b = 3'($urandom_range(0, 7));
            shift_in  = 2'($urandom_range(0, 3));
            out_ready = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                #2;
                reset_n = 1'b0;
                model_clear();
                #1;
                chk("rnd_rst_valid", {31'b0, out_valid}, 32'd0);
                step();
                reset_n = 1'b1;
            end else begin
                step();
            end
        end
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
